// File: rtl/keypad_scan_sequencer.sv
// 4x4 keypad scanner: column drive, per-frame classification, debounced press/release FSM, FWFT event FIFO.
// Optional auto-repeat while a key is held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan_sequencer #(
  parameter int unsigned SCAN_TICKS      = 100_000,
  parameter int unsigned SETTLE          = 10,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;
  typedef enum logic [1:0] {F_NONE, F_KEY, F_MULTI} frame_t;

  function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: key_at = 4'h1;  4'h1: key_at = 4'h4;  4'h2: key_at = 4'h7;  4'h3: key_at = 4'h0;
      4'h4: key_at = 4'h2;  4'h5: key_at = 4'h5;  4'h6: key_at = 4'h8;  4'h7: key_at = 4'hF;
      4'h8: key_at = 4'h3;  4'h9: key_at = 4'h6;  4'hA: key_at = 4'h9;  4'hB: key_at = 4'hE;
      4'hC: key_at = 4'hA;  4'hD: key_at = 4'hB;  4'hE: key_at = 4'hC;  default: key_at = 4'hD;
    endcase
  endfunction

  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    acc_n_q, acc_n_d, col_n, merged_n;
  logic [3:0]    acc_code_q, acc_code_d, col_code, merged_code;
  logic          frame_tick_q, frame_tick_d;
  frame_t        frame_kind_q, frame_kind_d;
  logic [3:0]    frame_code_q, frame_code_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d, push_code;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, full, do_push, ovf_set;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem [FIFO_DEPTH];

  assign col = ~(4'b1000 >> col_idx_q);

  // Row pins are asynchronous; two stages ahead of the sample point (SETTLE >= 2 absorbs them).
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      // NOTE: sequential state always uses non-blocking (<=) so every flop sees pre-edge values.
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    timer_d   = timer_q + TW'(1);
    col_idx_d = col_idx_q;
    if (timer_q == TW'(SCAN_TICKS - 1)) begin
      timer_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  // Hits saturate at 2 ("more than one"); the code is only meaningful when exactly one.
  always_comb begin
    col_n    = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[3-r]) begin
        col_n    = (col_n == 2'd0) ? 2'd1 : 2'd2;
        col_code = key_at(col_idx_q, 2'(r));
      end
    end
    merged_n     = (acc_n_q == 2'd0) ? col_n : ((col_n == 2'd0) ? acc_n_q : 2'd2);
    merged_code  = (col_n != 2'd0) ? col_code : acc_code_q;
    acc_n_d      = acc_n_q;
    acc_code_d   = acc_code_q;
    frame_tick_d = 1'b0;
    frame_kind_d = frame_kind_q;
    frame_code_d = frame_code_q;
    if (timer_q == TW'(SETTLE)) begin
      if (col_idx_q == 2'd3) begin
        frame_tick_d = 1'b1;
        frame_code_d = merged_code;
        acc_n_d      = 2'd0;
        acc_code_d   = 4'h0;
        case (merged_n)
          2'd0:    frame_kind_d = F_NONE;
          2'd1:    frame_kind_d = F_KEY;
          default: frame_kind_d = F_MULTI;
        endcase
      end else begin
        acc_n_d    = merged_n;
        acc_code_d = merged_code;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
`endif

  always_comb begin
    logic is_cand, reached;
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_code = cand_q;
    is_cand   = (frame_kind_q == F_KEY) && (frame_code_q == cand_q);
    reached   = (int'(cnt_q) + 1 >= int'(DEBOUNCE_FRAMES));
    if (frame_tick_q) begin
      case (state_q)
        S_IDLE: if (frame_kind_q == F_KEY) begin
          cand_d = frame_code_q;
          if (DEBOUNCE_FRAMES == 1) begin
            push      = 1'b1;
            push_code = frame_code_q;
            state_d   = S_HELD;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: if (is_cand) begin
          cnt_d = cnt_q + CW'(1);
          if (reached) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = S_HELD;
          end
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        S_HELD: if (!is_cand) begin
          cnt_d   = (frame_kind_q == F_NONE) ? CW'(1) : '0;
          state_d = (frame_kind_q == F_NONE && DEBOUNCE_FRAMES == 1) ? S_IDLE : S_RELEASE;
        end
        default: if (frame_kind_q == F_NONE) begin
          cnt_d = cnt_q + CW'(1);
          if (reached) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (is_cand) begin
          cnt_d   = '0;
          state_d = S_HELD;
        end else begin
          cnt_d = '0;
        end
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (state_q != S_HELD || state_d != S_HELD) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (frame_tick_q) begin
      if (rep_cnt_q + RW'(1) == (rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE))) begin
        push        = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
`endif
  end

  assign key_valid = (count_q != '0);
  assign full      = (count_q == FW'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign do_push   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign key_code  = key_valid ? mem[rd_ptr_q] : 4'h0;
  assign key_down  = (state_q == S_HELD) || (state_q == S_RELEASE);
  assign overflow  = overflow_q;

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + FW'(do_push) - FW'(pop);
    overflow_d = (overflow_q && !ovf_clr) || ovf_set;
  end

  // NOTE: FIFO storage has no reset; only the pointers/count are reset, and key_code is gated by key_valid.
  always_ff @(posedge clk_100MHz) begin
    if (do_push) mem[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      timer_q      <= '0;
      col_idx_q    <= 2'd0;
      acc_n_q      <= 2'd0;
      acc_code_q   <= 4'h0;
      frame_tick_q <= 1'b0;
      frame_kind_q <= F_NONE;
      frame_code_q <= 4'h0;
      state_q      <= S_IDLE;
      cand_q       <= 4'h0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q    <= '0;
      rep_first_q  <= 1'b1;
`endif
    end else begin
      timer_q      <= timer_d;
      col_idx_q    <= col_idx_d;
      acc_n_q      <= acc_n_d;
      acc_code_q   <= acc_code_d;
      frame_tick_q <= frame_tick_d;
      frame_kind_q <= frame_kind_d;
      frame_code_q <= frame_code_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
      rep_first_q  <= rep_first_d;
`endif
    end
  end

endmodule
